// File: rtl/snake_pkg.sv
// snake_pkg: shared board geometry, cell encodings and reader FSM states.
//   GRID_W / GRID_H : board size in cells (powers of two)
//   COORD_W         : coordinate width, log2(GRID_W)
//   cell_code_t     : 2-bit cell code stored in the board RAM
//   reader_state_t  : states of the board reader FSM
package snake_pkg;

   localparam int unsigned GRID_W  = 16;
   localparam int unsigned GRID_H  = 16;
   localparam int unsigned COORD_W = 4;

   typedef logic [1:0] cell_code_t;

   localparam cell_code_t CELL_EMPTY = 2'b00;
   localparam cell_code_t CELL_FOOD  = 2'b01;
   localparam cell_code_t CELL_SNAKE = 2'b10;
   localparam cell_code_t CELL_WALL  = 2'b11;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SCAN  = 2'd1,
      DRAIN = 2'd2,
      DONE  = 2'd3
   } reader_state_t;

endpackage

// File: rtl/read_tag_pipe.sv
// read_tag_pipe: DEPTH-stage shift register carrying {valid, x, y} so each
// issued board address lines up with the RAM data it produced.
//   clk, rst_n       : clock, asynchronous active-low reset (clears all stages)
//   valid_i, x_i, y_i: tag entering the pipe this cycle
//   valid_o, x_o, y_o: tag leaving the pipe, aligned with the RAM read data
module read_tag_pipe
   import snake_pkg::*;
#(
   parameter int unsigned DEPTH = 1
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               valid_i,
   input  logic [COORD_W-1:0] x_i,
   input  logic [COORD_W-1:0] y_i,
   output logic               valid_o,
   output logic [COORD_W-1:0] x_o,
   output logic [COORD_W-1:0] y_o
);

   logic [DEPTH-1:0]              valid_q;
   logic [DEPTH-1:0][COORD_W-1:0] x_q;
   logic [DEPTH-1:0][COORD_W-1:0] y_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid_q <= '0;
         x_q     <= '0;
         y_q     <= '0;
      end else begin
         valid_q[0] <= valid_i;
         x_q[0]     <= x_i;
         y_q[0]     <= y_i;
         for (int i = 1; i < DEPTH; i++) begin
            valid_q[i] <= valid_q[i-1];
            x_q[i]     <= x_q[i-1];
            y_q[i]     <= y_q[i-1];
         end
      end
   end

   assign valid_o = valid_q[DEPTH-1];
   assign x_o     = x_q[DEPTH-1];
   assign y_o     = y_q[DEPTH-1];

endmodule

// File: rtl/snake_board_reader.sv
// snake_board_reader: on request, raster-scans the whole board (x fastest)
// through a synchronous RAM read port and reports the first food cell, the
// number of snake cells and the code under the head, plus a collision flag.
//   clk, rst_n          : clock, asynchronous active-low reset
//   readBoard           : start request, only honoured in IDLE
//   headX, headY        : head position, latched at start
//   x_loc, y_loc, rd_en : board RAM read address and strobe
//   data_in             : cell code returned READ_LAT cycles after rd_en
//   busy, done          : scan in progress / one-cycle results-valid pulse
//   foodFound, foodX, foodY, snakeCount, headCode, collision : results
module snake_board_reader
   import snake_pkg::*;
#(
   parameter int unsigned READ_LAT = 1
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               readBoard,
   input  logic [COORD_W-1:0] headX,
   input  logic [COORD_W-1:0] headY,
   output logic [COORD_W-1:0] x_loc,
   output logic [COORD_W-1:0] y_loc,
   output logic               rd_en,
   input  logic [1:0]         data_in,
   output logic               busy,
   output logic               done,
   output logic               foodFound,
   output logic [COORD_W-1:0] foodX,
   output logic [COORD_W-1:0] foodY,
   output logic [8:0]         snakeCount,
   output logic [1:0]         headCode,
   output logic               collision
);

   reader_state_t      state_q, state_d;
   logic [COORD_W-1:0] head_x_q, head_x_d, head_y_q, head_y_d;
   logic [COORD_W-1:0] x_loc_q, x_loc_d, y_loc_q, y_loc_d;
   logic               rd_en_q, rd_en_d, busy_q, busy_d, done_q, done_d;
   logic               food_found_q, food_found_d;
   logic [COORD_W-1:0] food_x_q, food_x_d, food_y_q, food_y_d;
   logic [8:0]         snake_count_q, snake_count_d;
   cell_code_t         head_code_q, head_code_d;
   logic               collision_q, collision_d;
   logic [1:0]         drain_cnt_q, drain_cnt_d;

   logic               tag_valid;
   logic [COORD_W-1:0] tag_x, tag_y;

   read_tag_pipe #(
      .DEPTH(READ_LAT)
   ) u_tag_pipe (
      .clk    (clk),
      .rst_n  (rst_n),
      .valid_i(rd_en_q),
      .x_i    (x_loc_q),
      .y_i    (y_loc_q),
      .valid_o(tag_valid),
      .x_o    (tag_x),
      .y_o    (tag_y)
   );

   always_comb begin
      state_d       = state_q;
      head_x_d      = head_x_q;
      head_y_d      = head_y_q;
      x_loc_d       = x_loc_q;
      y_loc_d       = y_loc_q;
      rd_en_d       = rd_en_q;
      busy_d        = busy_q;
      done_d        = 1'b0;
      food_found_d  = food_found_q;
      food_x_d      = food_x_q;
      food_y_d      = food_y_q;
      snake_count_d = snake_count_q;
      head_code_d   = head_code_q;
      collision_d   = collision_q;
      drain_cnt_d   = drain_cnt_q;

      // Returned cell decode; the tag says which cell this data belongs to.
      if (tag_valid) begin
         if (data_in == CELL_SNAKE) snake_count_d = snake_count_q + 9'd1;
         if (data_in == CELL_FOOD && !food_found_q) begin
            food_found_d = 1'b1;
            food_x_d     = tag_x;
            food_y_d     = tag_y;
         end
         if (tag_x == head_x_q && tag_y == head_y_q) head_code_d = data_in;
      end

      unique case (state_q)
         IDLE: begin
            if (readBoard) begin
               head_x_d      = headX;
               head_y_d      = headY;
               food_found_d  = 1'b0;
               food_x_d      = '0;
               food_y_d      = '0;
               snake_count_d = '0;
               head_code_d   = CELL_EMPTY;
               collision_d   = 1'b0;
               x_loc_d       = '0;
               y_loc_d       = '0;
               rd_en_d       = 1'b1;
               busy_d        = 1'b1;
               state_d       = SCAN;
            end
         end
         SCAN: begin
            if (x_loc_q == COORD_W'(GRID_W - 1) && y_loc_q == COORD_W'(GRID_H - 1)) begin
               // Address stays on the last cell while rd_en is low.
               rd_en_d     = 1'b0;
               drain_cnt_d = '0;
               state_d     = DRAIN;
            end else begin
               x_loc_d = x_loc_q + 1'b1;
               if (x_loc_q == COORD_W'(GRID_W - 1)) y_loc_d = y_loc_q + 1'b1;
            end
         end
         DRAIN: begin
            if (drain_cnt_q == 2'(READ_LAT - 1)) begin
               // The last cell is decoded on this same edge, so use head_code_d.
               collision_d = (head_code_d == CELL_SNAKE) || (head_code_d == CELL_WALL);
               busy_d      = 1'b0;
               done_d      = 1'b1;
               state_d     = DONE;
            end else begin
               drain_cnt_d = drain_cnt_q + 2'd1;
            end
         end
         DONE: state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q       <= IDLE;
         head_x_q      <= '0;
         head_y_q      <= '0;
         x_loc_q       <= '0;
         y_loc_q       <= '0;
         rd_en_q       <= 1'b0;
         busy_q        <= 1'b0;
         done_q        <= 1'b0;
         food_found_q  <= 1'b0;
         food_x_q      <= '0;
         food_y_q      <= '0;
         snake_count_q <= '0;
         head_code_q   <= CELL_EMPTY;
         collision_q   <= 1'b0;
         drain_cnt_q   <= '0;
      end else begin
         state_q       <= state_d;
         head_x_q      <= head_x_d;
         head_y_q      <= head_y_d;
         x_loc_q       <= x_loc_d;
         y_loc_q       <= y_loc_d;
         rd_en_q       <= rd_en_d;
         busy_q        <= busy_d;
         done_q        <= done_d;
         food_found_q  <= food_found_d;
         food_x_q      <= food_x_d;
         food_y_q      <= food_y_d;
         snake_count_q <= snake_count_d;
         head_code_q   <= head_code_d;
         collision_q   <= collision_d;
         drain_cnt_q   <= drain_cnt_d;
      end
   end

   assign x_loc      = x_loc_q;
   assign y_loc      = y_loc_q;
   assign rd_en      = rd_en_q;
   assign busy       = busy_q;
   assign done       = done_q;
   assign foodFound  = food_found_q;
   assign foodX      = food_x_q;
   assign foodY      = food_y_q;
   assign snakeCount = snake_count_q;
   assign headCode   = head_code_q;
   assign collision  = collision_q;

endmodule

// File: tb/tb_snake_board_reader.sv
// Bench: two readers (READ_LAT 1 and 3) share the request inputs and a board
// image; each has its own RAM latency model. Expected results come from a
// raster walk of the board image.
module tb_snake_board_reader;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic            rst_n, readBoard;
   logic [3:0]      headX, headY;
   logic [1:0]      rd_en, busy, done, food_found, collision;
   logic [1:0][3:0] x_loc, y_loc, food_x, food_y;
   logic [1:0][8:0] snake_count;
   logic [1:0][1:0] head_code, data_in;

   logic [1:0] board [256];

   int checks = 0;
   int errors = 0;
   int done_cnt [2];
   int done_at  [2][2];
   int busy_bad [2];
   int addr_bad [2];
   logic [20:0] exp_res;

   for (genvar g = 0; g < 2; g++) begin : g_dut
      logic [2:0][1:0] ram_q;

      snake_board_reader #(
         .READ_LAT((g == 0) ? 1 : 3)
      ) u_dut (
         .clk       (clk),
         .rst_n     (rst_n),
         .readBoard (readBoard),
         .headX     (headX),
         .headY     (headY),
         .x_loc     (x_loc[g]),
         .y_loc     (y_loc[g]),
         .rd_en     (rd_en[g]),
         .data_in   (data_in[g]),
         .busy      (busy[g]),
         .done      (done[g]),
         .foodFound (food_found[g]),
         .foodX     (food_x[g]),
         .foodY     (food_y[g]),
         .snakeCount(snake_count[g]),
         .headCode  (head_code[g]),
         .collision (collision[g])
      );

      // Board RAM: garbage on the bus whenever no read was issued.
      always @(posedge clk) begin
         ram_q[0] <= rd_en[g] ? board[{y_loc[g], x_loc[g]}] : 2'($urandom);
         ram_q[1] <= ram_q[0];
         ram_q[2] <= ram_q[1];
      end
      assign data_in[g] = ram_q[(g == 0) ? 0 : 2];
   end

   function automatic int lat(input int d);
      return (d == 0) ? 1 : 3;
   endfunction

   function automatic logic [20:0] got_res(input int d);
      return {food_found[d], food_x[d], food_y[d], snake_count[d], head_code[d], collision[d]};
   endfunction

   function automatic logic [31:0] got_all(input int d);
      return {x_loc[d], y_loc[d], rd_en[d], busy[d], done[d], got_res(d)};
   endfunction

   // Reference: walk the board in raster order using the cell meanings.
   task automatic model(input logic [3:0] hx, input logic [3:0] hy);
      logic       ff = 1'b0;
      logic [3:0] fx = '0, fy = '0;
      logic [1:0] hc = '0;
      int         cnt = 0;
      for (int y = 0; y < 16; y++) begin
         for (int x = 0; x < 16; x++) begin
            logic [1:0] c = board[y*16 + x];
            if (c == 2'b10) cnt++;
            if (c == 2'b01 && !ff) begin
               ff = 1'b1; fx = 4'(x); fy = 4'(y);
            end
            if (x == int'(hx) && y == int'(hy)) hc = c;
         end
      end
      exp_res = {ff, fx, fy, 9'(cnt), hc, (hc == 2'b10 || hc == 2'b11)};
   endtask

   task automatic fill_random();
      for (int i = 0; i < 256; i++) begin
         int r = $urandom_range(0, 15);
         board[i] = (r < 10) ? 2'b00 : (r == 10) ? 2'b01 : (r < 14) ? 2'b10 : 2'b11;
      end
   endtask

   // Starts a scan (readBoard already high) and monitors ncyc cycles after it.
   task automatic watch(input int ncyc, input int pulse_at, input int hold_until);
      for (int d = 0; d < 2; d++) begin
         done_cnt[d] = 0; done_at[d][0] = -1; done_at[d][1] = -1;
         busy_bad[d] = 0; addr_bad[d] = 0;
      end
      @(posedge clk); #1;
      if (hold_until == 0) readBoard = 1'b0;
      for (int n = 1; n <= ncyc; n++) begin
         for (int d = 0; d < 2; d++) begin
            if (done[d]) begin
               if (done_cnt[d] < 2) done_at[d][done_cnt[d]] = n;
               done_cnt[d]++;
            end
            if (n <= 257 + lat(d) && busy[d] !== (n <= 256 + lat(d))) busy_bad[d]++;
            if (n <= 256) begin
               if (rd_en[d] !== 1'b1 || x_loc[d] !== 4'((n-1) % 16) || y_loc[d] !== 4'((n-1) / 16))
                  addr_bad[d]++;
            end else if (n <= 256 + lat(d)) begin
               if (rd_en[d] !== 1'b0 || x_loc[d] !== 4'd15 || y_loc[d] !== 4'd15) addr_bad[d]++;
            end
         end
         if (pulse_at > 0 && n == pulse_at) begin
            readBoard = 1'b1; headX = headX + 4'd7; headY = ~headY;
         end else if (pulse_at > 0 && n == pulse_at + 1) begin
            readBoard = 1'b0;
         end
         if (n == hold_until) readBoard = 1'b0;
         @(posedge clk); #1;
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0; readBoard = 1'b0; headX = '0; headY = '0;
      repeat (3) @(posedge clk);
      #1;
      for (int d = 0; d < 2; d++) begin
         checks++;
         if (got_all(d) !== 32'd0) begin
            errors++; $display("FAIL reset_state dut%0d: got %h want 0", d, got_all(d));
         end
      end
      rst_n = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      for (int d = 0; d < 2; d++) begin
         checks++;
         if (got_all(d) !== 32'd0) begin
            errors++; $display("FAIL idle_after_reset dut%0d: got %h want 0", d, got_all(d));
         end
      end
   endtask

   // One scan of the current board with head (hx,hy) and full result checks.
   task automatic test_scan(input string name, input logic [3:0] hx, input logic [3:0] hy);
      headX = hx; headY = hy; model(hx, hy);
      readBoard = 1'b1;
      watch(270, 0, 0);
      for (int d = 0; d < 2; d++) begin
         checks++;
         if (done_cnt[d] !== 1 || done_at[d][0] !== 257 + lat(d)) begin
            errors++;
            $display("FAIL %s_done dut%0d: got %0d pulses first at cycle %0d, want 1 at %0d",
                     name, d, done_cnt[d], done_at[d][0], 257 + lat(d));
         end
         checks++;
         if (busy_bad[d] !== 0 || addr_bad[d] !== 0) begin
            errors++;
            $display("FAIL %s_busy_addr dut%0d: got %0d busy / %0d address bad cycles, want 0/0",
                     name, d, busy_bad[d], addr_bad[d]);
         end
         checks++;
         if (got_res(d) !== exp_res) begin
            errors++; $display("FAIL %s_results dut%0d: got %h want %h", name, d, got_res(d), exp_res);
         end
      end
   endtask

   task automatic test_boards();
      for (int i = 0; i < 256; i++) board[i] = 2'b00;
      test_scan("empty", 4'd5, 4'd5);
      for (int i = 0; i < 256; i++) board[i] = 2'b00;
      board[2*16+3] = 2'b10; board[2*16+4] = 2'b10; board[2*16+5] = 2'b10;
      board[7*16+9] = 2'b01; board[12*16+1] = 2'b01;
      test_scan("pattern", 4'd5, 4'd2);
      for (int i = 0; i < 256; i++) board[i] = 2'b00;
      board[0] = 2'b11;
      test_scan("wall", 4'd0, 4'd0);
      for (int i = 0; i < 256; i++) board[i] = 2'b10;
      test_scan("full_snake", 4'd9, 4'd14);
      for (int i = 0; i < 256; i++) board[i] = 2'b00;
      board[255] = 2'b01;
      test_scan("food_corner", 4'd15, 4'd15);
   endtask

   task automatic test_random();
      for (int k = 0; k < 4; k++) begin
         fill_random();
         test_scan("random", 4'($urandom), 4'($urandom));
      end
   endtask

   task automatic test_ignore_restart();
      fill_random();
      headX = 4'($urandom); headY = 4'($urandom); model(headX, headY);
      readBoard = 1'b1;
      watch(300, 40, 0);
      for (int d = 0; d < 2; d++) begin
         checks++;
         if (done_cnt[d] !== 1 || done_at[d][0] !== 257 + lat(d) || addr_bad[d] !== 0) begin
            errors++;
            $display("FAIL ignore_done dut%0d: got %0d pulses at %0d, %0d bad addr, want 1 at %0d, 0",
                     d, done_cnt[d], done_at[d][0], addr_bad[d], 257 + lat(d));
         end
         checks++;
         if (got_res(d) !== exp_res) begin
            errors++; $display("FAIL ignore_results dut%0d: got %h want %h", d, got_res(d), exp_res);
         end
      end
   endtask

   task automatic test_back_to_back();
      fill_random();
      headX = 4'($urandom); headY = 4'($urandom); model(headX, headY);
      readBoard = 1'b1;
      watch(540, 0, 265);
      for (int d = 0; d < 2; d++) begin
         checks++;
         if (done_cnt[d] !== 2 || done_at[d][0] !== 257 + lat(d) ||
             done_at[d][1] !== 515 + 2*lat(d)) begin
            errors++;
            $display("FAIL b2b_done dut%0d: got %0d pulses at %0d,%0d want 2 at %0d,%0d", d,
                     done_cnt[d], done_at[d][0], done_at[d][1], 257 + lat(d), 515 + 2*lat(d));
         end
         checks++;
         if (got_res(d) !== exp_res) begin
            errors++; $display("FAIL b2b_results dut%0d: got %h want %h", d, got_res(d), exp_res);
         end
      end
   endtask

   task automatic test_reset_mid_scan();
      int dones = 0;
      fill_random();
      headX = 4'($urandom); headY = 4'($urandom);
      readBoard = 1'b1;
      @(posedge clk); #1;
      readBoard = 1'b0;
      repeat (99) @(posedge clk);
      #1;
      checks++;
      if (busy !== 2'b11) begin
         errors++; $display("FAIL midscan_busy: got %b want 11", busy);
      end
      rst_n = 1'b0;
      #1;
      for (int d = 0; d < 2; d++) begin
         checks++;
         if (got_all(d) !== 32'd0) begin
            errors++; $display("FAIL async_reset dut%0d: got %h want 0", d, got_all(d));
         end
      end
      repeat (5) begin
         @(posedge clk); #1;
         if (done !== 2'b00) dones++;
      end
      checks++;
      if (dones !== 0) begin
         errors++; $display("FAIL reset_no_done: got %0d done cycles want 0", dones);
      end
      rst_n = 1'b1;
      @(posedge clk); #1;
      fill_random();
      test_scan("after_reset", 4'($urandom), 4'($urandom));
   endtask

   initial begin
      test_reset();
      test_boards();
      test_random();
      test_ignore_restart();
      test_back_to_back();
      test_reset_mid_scan();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/snake_board_reader.md
Name: snake_board_reader

Overview:
Reader side of the board memory that the snake writer fills. On request it raster-scans every cell of the 16x16 board through a synchronous read port and decodes the 2-bit cell codes. It reports the first food location, the number of snake cells, and the code found at a supplied head position, with a collision flag. It sits between the board RAM read port and the game-control FSM, which uses the results to decide growth and game-over.

Parameters:
GRID_W, 16, board width in cells (power of two)
GRID_H, 16, board height in cells (power of two)
COORD_W, 4, coordinate width, log2(GRID_W)
READ_LAT, 1, board RAM read latency in cycles (1..3)

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
readBoard  in  1  start request, sampled only in IDLE
headX  in  COORD_W  head x coordinate, latched at start
headY  in  COORD_W  head y coordinate, latched at start
x_loc  out  COORD_W  board read address x
y_loc  out  COORD_W  board read address y
rd_en  out  1  board read strobe
data_in  in  2  cell code returned READ_LAT cycles after rd_en
busy  out  1  high from the cycle after start until done
done  out  1  one-cycle pulse when results are valid
foodFound  out  1  at least one food cell seen
foodX  out  COORD_W  x of first food cell in raster order
foodY  out  COORD_W  y of first food cell in raster order
snakeCount  out  9  number of snake cells (0..256)
headCode  out  2  cell code at (headX, headY)
collision  out  1  headCode is snake or wall

Behaviour:
- Cell codes: 00 empty, 01 food, 10 snake, 11 wall.
- Reset values: x_loc=0, y_loc=0, rd_en=0, busy=0, done=0, foodFound=0, foodX=0, foodY=0, snakeCount=0, headCode=0, collision=0. FSM goes to IDLE and the tag pipeline is cleared.
- FSM states:
  - IDLE: when readBoard=1, latch the head coordinates, clear all result registers, and go to SCAN.
  - SCAN: issue one address per cycle with rd_en=1. Order is raster, x fastest: (0,0),(1,0)…(15,0),(0,1)…(15,15). After issuing (15,15), go to DRAIN.
  - DRAIN: rd_en=0. Wait READ_LAT cycles for outstanding data, then go to DONE.
  - DONE: done=1 for exactly one cycle, then return to IDLE.
- Timing: readBoard is sampled at edge 0. The first address is driven in cycle 1 and the last in cycle 256. done is high in cycle 257+READ_LAT. busy is high in cycles 1..256+READ_LAT.
- Each issued (x,y) travels through a READ_LAT-deep tag pipeline alongside a valid bit. data_in is processed only when the tag is valid.
- Processing per valid returned cell:
  - code 10: snakeCount += 1. The 9-bit counter cannot overflow.
  - code 01 with foodFound=0: capture foodX/foodY and set foodFound. Later food cells are ignored.
  - tag equal to the latched head: headCode = data_in.
- collision is registered from headCode and valid in the DONE cycle.
- Results hold their values from done until the next accepted start.
- readBoard while busy is ignored, with no queuing. readBoard held high across DONE starts a new scan from the following IDLE cycle.
- headX/headY changes during a scan have no effect.
- x_loc/y_loc keep their last value when rd_en=0.
- rst_n low mid-scan aborts immediately: all outputs return to reset values and no done is generated.

Decomposition:
- Package snake_pkg holds:
  - CELL_EMPTY, CELL_FOOD, CELL_SNAKE, CELL_WALL constants
  - GRID_W, GRID_H, COORD_W
  - a cell_code_t 2-bit typedef
  - a reader_state_t enum (IDLE, SCAN, DRAIN, DONE)
- The tag pipeline is a natural sub-module, read_tag_pipe: a parameterised READ_LAT-stage shift register carrying {valid, x, y} with async active-low reset.

Test Plan:
- Empty board (all 00), head (5,5), READ_LAT=1 -> done in cycle 258; snakeCount=0, foodFound=0, headCode=00, collision=0.
- Snake cells at (3,2),(4,2),(5,2), food at (9,7) and (1,12), head (5,2) -> snakeCount=3, foodX=9, foodY=7, headCode=10, collision=1.
- Wall at (0,0), head (0,0), READ_LAT=3 -> headCode=11, collision=1; done in cycle 260; busy high cycles 1..259.
- Full board of snake cells -> snakeCount=256. Food at (15,15) only -> foodFound=1, foodX=15, foodY=15.
- readBoard pulsed at cycle 40 of a scan, and headX changed mid-scan -> no restart, results reflect the head latched at start, exactly one done pulse.
- rst_n asserted at cycle 100 of a scan -> all outputs zero asynchronously, no done. After release, a new readBoard produces a correct full scan.
